// File: rtl/serial_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : serial_regbank
//  Description : Byte-protocol register bank behind a serial receiver /
//                transmitter pair. 'W' addr data writes a register and
//                answers 'K'; 'R' addr answers with the register contents.
//                Bad opcodes or addresses answer '?'. A spacing gap follows
//                each response.
//                Optional feature macro: SERIAL_REGBANK_TIMEOUT_EN. When it is
//                defined, an idle-line timeout abandons half-received packets.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_regbank #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int TX_GAP   = (CLK_FREQ / BAUD) * 12,
    parameter int TIMEOUT  = (CLK_FREQ / BAUD) * 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   dat_r,
    input  logic         ready,
    output logic         ready_rst,
    output logic [7:0]   dat_t,
    output logic         txe,
    output logic [127:0] regs,
    output logic         busy
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_GET_ADDR = 3'd1;
    localparam logic [2:0] c_GET_DATA = 3'd2;
    localparam logic [2:0] c_RESP     = 3'd3;
    localparam logic [2:0] c_GAP      = 3'd4;

    localparam logic [7:0] c_OP_WRITE = 8'h57;
    localparam logic [7:0] c_OP_READ  = 8'h52;
    localparam logic [7:0] c_RSP_ERR  = 8'h3F;
    localparam logic [7:0] c_RSP_OK   = 8'h4B;

    // Gap counter is wide enough to hold TX_GAP itself; a zero gap degrades
    // to a single GAP cycle.
    localparam int c_GAP_W    = (TX_GAP < 2) ? 1 : $clog2(TX_GAP + 1);
    localparam int c_GAP_LAST = (TX_GAP > 0) ? TX_GAP - 1 : 0;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               w_accept;
    logic               w_in_packet;
    logic               w_timeout;
    logic               w_resp_load;
    logic [7:0]         w_resp_val;
    logic               w_write;
    logic               w_gap_done;
    logic               r_ready_rst;
    logic               r_is_read;
    logic [3:0]         r_addr;
    logic [7:0]         r_resp;
    logic [7:0]         r_regs [16];
    logic [c_GAP_W-1:0] r_gap_cnt;

    // A byte is taken only while listening, and never in the clear cycle
    // where the stale ready level may still be visible.
    assign w_accept    = ready && !r_ready_rst &&
                         ((r_state == c_IDLE) || (r_state == c_GET_ADDR) ||
                          (r_state == c_GET_DATA));
    assign w_in_packet = (r_state == c_GET_ADDR) || (r_state == c_GET_DATA);
    assign w_write     = (r_state == c_GET_DATA) && w_accept;
    assign w_gap_done  = (r_gap_cnt == c_GAP_W'(c_GAP_LAST));

`ifdef SERIAL_REGBANK_TIMEOUT_EN
    localparam int c_TO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int c_TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [c_TO_W-1:0] r_to_cnt;

    // Inactivity counter: restarts on every accepted byte and outside packets.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_to_cnt <= '0;
        end else if (w_accept || !w_in_packet) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = w_in_packet && !w_accept &&
                       (r_to_cnt == c_TO_W'(c_TO_LAST));
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode, also selecting the response byte on entry to RESP.
    always_comb begin
        w_state_nxt = r_state;
        w_resp_load = 1'b0;
        w_resp_val  = c_RSP_ERR;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if ((dat_r == c_OP_WRITE) || (dat_r == c_OP_READ)) begin
                        w_state_nxt = c_GET_ADDR;
                    end else begin
                        w_state_nxt = c_RESP;
                        w_resp_load = 1'b1;
                        w_resp_val  = c_RSP_ERR;
                    end
                end
            end
            c_GET_ADDR: begin
                if (w_accept) begin
                    if (dat_r[7:4] != 4'h0) begin
                        w_state_nxt = c_RESP;
                        w_resp_load = 1'b1;
                        w_resp_val  = c_RSP_ERR;
                    end else if (r_is_read) begin
                        w_state_nxt = c_RESP;
                        w_resp_load = 1'b1;
                        w_resp_val  = r_regs[dat_r[3:0]];
                    end else begin
                        w_state_nxt = c_GET_DATA;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_GET_DATA: begin
                if (w_accept) begin
                    w_state_nxt = c_RESP;
                    w_resp_load = 1'b1;
                    w_resp_val  = c_RSP_OK;
                end else if (w_timeout) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_RESP: begin
                w_state_nxt = c_GAP;
            end
            c_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Output decode; dat_t is the held response so it keeps its value off-strobe.
    always_comb begin
        busy      = (r_state != c_IDLE);
        txe       = (r_state == c_RESP);
        dat_t     = r_resp;
        ready_rst = r_ready_rst;
    end

    // Packet context: ready clear pulse, opcode, address, response, gap count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ready_rst <= 1'b0;
            r_is_read   <= 1'b0;
            r_addr      <= 4'h0;
            r_resp      <= 8'h00;
            r_gap_cnt   <= '0;
        end else begin
            r_ready_rst <= w_accept;
            if ((r_state == c_IDLE) && w_accept) begin
                r_is_read <= (dat_r == c_OP_READ);
            end
            if ((r_state == c_GET_ADDR) && w_accept && (dat_r[7:4] == 4'h0)) begin
                r_addr <= dat_r[3:0];
            end
            if (w_resp_load) begin
                r_resp <= w_resp_val;
            end
            if (r_state == c_GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    // Register file; a write lands on the edge that accepts the data byte.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (w_write) begin
            r_regs[r_addr] <= dat_r;
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_regs
        assign regs[8*i +: 8] = r_regs[i];
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_regbank
//  Description : Self-checking bench for serial_regbank. Responses are
//                collected by a monitor and matched against an expected-byte
//                queue filled as packets are sent. Build with
//                SERIAL_REGBANK_TIMEOUT_EN to cover the timeout behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_regbank;

    localparam int TX_GAP  = 20;
    localparam int TIMEOUT = 50;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic [7:0]   dat_r = 8'h00;
    logic         ready = 1'b0;
    logic         ready_rst;
    logic [7:0]   dat_t;
    logic         txe;
    logic [127:0] regs;
    logic         busy;

    int           n_checks = 0;
    int           n_fails  = 0;
    int           rr_pulses = 0;
    logic [7:0]   exp_q [$];
    logic [7:0]   got_q [$];
    logic [7:0]   exp_regs [16];

    serial_regbank #(
        .CLK_FREQ (50_000_000),
        .BAUD     (9600),
        .TX_GAP   (TX_GAP),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dat_r     (dat_r),
        .ready     (ready),
        .ready_rst (ready_rst),
        .dat_t     (dat_t),
        .txe       (txe),
        .regs      (regs),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Monitor: record every transmitted byte and every ready clear pulse.
    always @(negedge clk) begin
        if (txe) got_q.push_back(dat_t);
        if (ready_rst) rr_pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    function automatic logic [127:0] pack_regs();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = exp_regs[i];
        return v;
    endfunction

    // Present a byte like the serial receiver: ready held until cleared.
    task automatic send_byte(input logic [7:0] b);
        int k;
        @(negedge clk);
        dat_r = b;
        ready = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (ready_rst) break;
        end
        ready = 1'b0;
        if (k == 200) begin
            n_checks++; n_fails++;
            $display("FAIL send_byte: byte %h never cleared, got no ready_rst, expected one", b);
        end
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (k == 200) begin
            n_checks++; n_fails++;
            $display("FAIL wait_idle: busy stuck at %b, expected 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (regs !== 128'h0) begin n_fails++; $display("FAIL reset_regs: got %h expected 0", regs); end
        n_checks++; if (txe !== 1'b0) begin n_fails++; $display("FAIL reset_txe: got %b expected 0", txe); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (dat_t !== 8'h00) begin n_fails++; $display("FAIL reset_dat_t: got %h expected 00", dat_t); end
        n_checks++; if (ready_rst !== 1'b0) begin n_fails++; $display("FAIL reset_ready_rst: got %b expected 0", ready_rst); end
        rst = 1'b1;
        for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_write();
        int k;
        int gap;
        exp_q.push_back(8'h4B);
        exp_regs[3] = 8'hA5;
        send_byte(8'h57); send_byte(8'h03); send_byte(8'hA5);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (txe) break;
        end
        gap = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            gap++;
            if (!busy) break;
        end
        n_checks++; if (gap !== TX_GAP + 1) begin n_fails++; $display("FAIL write_gap: busy fell %0d cycles after txe, expected %0d", gap, TX_GAP + 1); end
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fails++; $display("FAIL write_count: got %0d txe, expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (g !== e) begin n_fails++; $display("FAIL write_resp: got %h expected %h", g, e); end
        end
        n_checks++; if (regs[31:24] !== 8'hA5) begin n_fails++; $display("FAIL write_reg3: got %h expected a5", regs[31:24]); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_read();
        exp_q.push_back(exp_regs[3]);
        send_byte(8'h52); send_byte(8'h03);
        wait_idle();
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fails++; $display("FAIL read_count: got %0d txe, expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (g !== e) begin n_fails++; $display("FAIL read_resp: got %h expected %h", g, e); end
        end
        n_checks++; if (regs !== pack_regs()) begin n_fails++; $display("FAIL read_regs: got %h expected %h", regs, pack_regs()); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_bad_packets();
        exp_q.push_back(8'h3F);
        exp_q.push_back(8'h3F);
        send_byte(8'h41);
        wait_idle();
        send_byte(8'h52); send_byte(8'h10);
        wait_idle();
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fails++; $display("FAIL bad_count: got %0d txe, expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (g !== e) begin n_fails++; $display("FAIL bad_resp: got %h expected %h", g, e); end
        end
        n_checks++; if (regs !== pack_regs()) begin n_fails++; $display("FAIL bad_regs: got %h expected %h", regs, pack_regs()); end
        exp_q.delete(); got_q.delete();
    endtask

    // Ready held high with no regard to ready_rst: only one byte may be taken.
    task automatic test_ready_hold();
        int start;
        start = rr_pulses;
        exp_q.push_back(8'h3F);
        @(negedge clk);
        dat_r = 8'h41;
        ready = 1'b1;
        repeat (5) @(negedge clk);
        ready = 1'b0;
        wait_idle();
        n_checks++; if (rr_pulses - start !== 1) begin n_fails++; $display("FAIL hold_ready_rst: got %0d pulses expected 1", rr_pulses - start); end
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fails++; $display("FAIL hold_count: got %0d txe, expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (g !== e) begin n_fails++; $display("FAIL hold_resp: got %h expected %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    // A byte arriving during RESP/GAP waits and is taken once IDLE is reached.
    task automatic test_back_to_back();
        int k;
        exp_q.push_back(8'h3F);
        exp_q.push_back(8'h3F);
        send_byte(8'h41);
        @(negedge clk);
        dat_r = 8'h41;
        ready = 1'b1;
        k = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            k++;
            if (ready_rst) break;
        end
        ready = 1'b0;
        n_checks++; if (k !== TX_GAP + 2) begin n_fails++; $display("FAIL pending_accept: ready_rst at cycle %0d, expected %0d", k, TX_GAP + 2); end
        wait_idle();
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fails++; $display("FAIL pending_count: got %0d txe, expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (g !== e) begin n_fails++; $display("FAIL pending_resp: got %h expected %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_timeout();
`ifdef SERIAL_REGBANK_TIMEOUT_EN
        int k;
        send_byte(8'h57);
        k = 0;
        for (int j = 0; j < 100; j++) begin
            @(posedge clk); #1;
            k++;
            if (!busy) break;
        end
        n_checks++; if (k !== TIMEOUT) begin n_fails++; $display("FAIL timeout_cycles: idle after %0d cycles, expected %0d", k, TIMEOUT); end
        repeat (10) @(negedge clk);
        n_checks++; if (got_q.size() !== 0) begin n_fails++; $display("FAIL timeout_txe: got %0d txe, expected 0", got_q.size()); end
        got_q.delete();
        exp_q.push_back(exp_regs[0]);
        send_byte(8'h52); send_byte(8'h00);
`else
        send_byte(8'h57);
        repeat (60) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL no_timeout_busy: got %b expected 1", busy); end
        n_checks++; if (got_q.size() !== 0) begin n_fails++; $display("FAIL no_timeout_txe: got %0d txe, expected 0", got_q.size()); end
        got_q.delete();
        exp_q.push_back(8'h3F);
        send_byte(8'hF0);
`endif
        wait_idle();
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fails++; $display("FAIL timeout_count: got %0d txe, expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (g !== e) begin n_fails++; $display("FAIL timeout_resp: got %h expected %h", g, e); end
        end
        n_checks++; if (regs !== pack_regs()) begin n_fails++; $display("FAIL timeout_regs: got %h expected %h", regs, pack_regs()); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_in_gap();
        exp_q.push_back(8'h3F);
        send_byte(8'h41);
        repeat (5) @(negedge clk);
        n_checks++; if (got_q.size() !== 1) begin n_fails++; $display("FAIL rgap_pre_count: got %0d txe, expected 1", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (g !== e) begin n_fails++; $display("FAIL rgap_pre_resp: got %h expected %h", g, e); end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (txe !== 1'b0) begin n_fails++; $display("FAIL rgap_txe: got %b expected 0", txe); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL rgap_busy: got %b expected 0", busy); end
        n_checks++; if (regs !== 128'h0) begin n_fails++; $display("FAIL rgap_regs: got %h expected 0", regs); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
        exp_q.delete(); got_q.delete();
        exp_q.push_back(exp_regs[3]);
        send_byte(8'h52); send_byte(8'h03);
        wait_idle();
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fails++; $display("FAIL rgap_count: got %0d txe, expected %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (g !== e) begin n_fails++; $display("FAIL rgap_resp: got %h expected %h", g, e); end
        end
        n_checks++; if (regs !== pack_regs()) begin n_fails++; $display("FAIL rgap_regs_after: got %h expected %h", regs, pack_regs()); end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_packets();
        test_ready_hold();
        test_back_to_back();
        test_timeout();
        test_reset_in_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
